// File: rtl/el2_dccm_sink_pkg.sv
// Shared types for the DCCM SRAM sink: injection FSM states and the
// default {ecc,data} bank word layout.
package el2_dccm_sink_pkg;

  localparam int DCCM_DATA_W = 32;
  localparam int DCCM_ECC_W  = 7;

  typedef logic [DCCM_DATA_W+DCCM_ECC_W-1:0] dccm_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM_T,
    ARM_P
  } inj_state_e;

endpackage

// File: rtl/el2_dccm_sink_bank.sv
// One DCCM bank: {ecc,data} array with a registered read port, a read-path
// XOR overlay for transient faults and an in-place XOR strobe for persistent ones.
module el2_dccm_sink_bank #(
  parameter int WORD_W    = 39,
  parameter int IDX_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 clken,
  input  logic                 wren,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic                 ovl_en,
  input  logic                 rmw_en,
  input  logic [IDX_WIDTH-1:0] rmw_idx,
  input  logic [WORD_W-1:0]    xor_mask,
  output logic [WORD_W-1:0]    rd_word
);

  localparam int DEPTH = 2 ** IDX_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ovl;

  assign ovl = ovl_en ? xor_mask : '0;

  // The RMW strobe is only raised while the bank is idle, so it never races a core write.
  always_ff @(posedge clk) begin
    if (clken && wren) begin
      mem[idx] <= wr_word;
    end else if (rmw_en) begin
      mem[rmw_idx] <= mem[rmw_idx] ^ xor_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_word <= '0;
    end else if (clken && !wren) begin
      rd_word <= mem[idx] ^ ovl;
    end
  end

endmodule

// File: rtl/el2_dccm_sram_sink.sv
// DCCM memory-side responder: NUM_BANKS independent SRAM banks plus an
// error-injection engine that corrupts one read (transient) or one stored word (persistent).
module el2_dccm_sram_sink
  import el2_dccm_sink_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7,
  parameter int IDX_WIDTH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic [NUM_BANKS-1:0]            dccm_clken,
  input  logic [NUM_BANKS-1:0]            dccm_wren_bank,
  input  logic [NUM_BANKS*IDX_WIDTH-1:0]  dccm_addr_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] dccm_wr_data_bank,
  input  logic [NUM_BANKS*ECC_WIDTH-1:0]  dccm_wr_ecc_bank,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] dccm_bank_dout,
  output logic [NUM_BANKS*ECC_WIDTH-1:0]  dccm_bank_ecc,
  input  logic                            inj_req,
  input  logic                            inj_persist,
  input  logic [$clog2(NUM_BANKS)-1:0]    inj_bank,
  input  logic [IDX_WIDTH-1:0]            inj_idx,
  input  logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask,
  output logic                            inj_busy,
  output logic                            inj_done,
  output logic [CNT_WIDTH-1:0]            inj_count
);

  localparam int WORD_W = DATA_WIDTH + ECC_WIDTH;
  localparam int BANK_W = $clog2(NUM_BANKS);

  inj_state_e state, next_state;

  logic [BANK_W-1:0]    bank_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [WORD_W-1:0]    mask_q;
  logic                 fire_t, fire_p;
  logic                 tgt_clken, tgt_wren;
  logic [IDX_WIDTH-1:0] tgt_addr;
  logic [WORD_W-1:0]    rd_word [NUM_BANKS];

  assign tgt_clken = dccm_clken[bank_q];
  assign tgt_wren  = dccm_wren_bank[bank_q];
  assign tgt_addr  = dccm_addr_bank[bank_q*IDX_WIDTH +: IDX_WIDTH];
  assign inj_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= IDLE;
      bank_q <= '0;
      idx_q  <= '0;
      mask_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && inj_req) begin
        bank_q <= inj_bank;
        idx_q  <= inj_idx;
        mask_q <= inj_mask;
      end
    end
  end

  always_comb begin
    next_state = state;
    fire_t     = 1'b0;
    fire_p     = 1'b0;
    unique case (state)
      IDLE: begin
        if (inj_req) next_state = inj_persist ? ARM_P : ARM_T;
      end
      ARM_T: begin
        if (tgt_clken && !tgt_wren && (tgt_addr == idx_q)) begin
          fire_t     = 1'b1;
          next_state = IDLE;
        end
      end
      ARM_P: begin
        if (!tgt_clken) begin
          fire_p     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Done and count update on the firing edge, so both are visible alongside the corrupted dout.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      inj_done  <= 1'b0;
      inj_count <= '0;
    end else begin
      inj_done <= fire_t | fire_p;
      if ((fire_t || fire_p) && (inj_count != {CNT_WIDTH{1'b1}})) begin
        inj_count <= inj_count + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    el2_dccm_sink_bank #(
      .WORD_W    (WORD_W),
      .IDX_WIDTH (IDX_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rst_l    (rst_l),
      .clken    (dccm_clken[b]),
      .wren     (dccm_wren_bank[b]),
      .idx      (dccm_addr_bank[b*IDX_WIDTH +: IDX_WIDTH]),
      .wr_word  ({dccm_wr_ecc_bank[b*ECC_WIDTH +: ECC_WIDTH],
                  dccm_wr_data_bank[b*DATA_WIDTH +: DATA_WIDTH]}),
      .ovl_en   (fire_t && (bank_q == BANK_W'(b))),
      .rmw_en   (fire_p && (bank_q == BANK_W'(b))),
      .rmw_idx  (idx_q),
      .xor_mask (mask_q),
      .rd_word  (rd_word[b])
    );

    assign dccm_bank_dout[b*DATA_WIDTH +: DATA_WIDTH] = rd_word[b][DATA_WIDTH-1:0];
    assign dccm_bank_ecc[b*ECC_WIDTH +: ECC_WIDTH]    = rd_word[b][WORD_W-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
// Directed bench for el2_dccm_sram_sink: bank access, transient/persistent
// injection, reset mid-arm and counter saturation (counter shrunk to 3 bits).
module tb_el2_dccm_sram_sink;

  localparam int NB = 4;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int IW = 12;
  localparam int CW = 3;

  logic             clk;
  logic             rst_l;
  logic [NB-1:0]    dccm_clken;
  logic [NB-1:0]    dccm_wren_bank;
  logic [NB*IW-1:0] dccm_addr_bank;
  logic [NB*DW-1:0] dccm_wr_data_bank;
  logic [NB*EW-1:0] dccm_wr_ecc_bank;
  logic [NB*DW-1:0] dccm_bank_dout;
  logic [NB*EW-1:0] dccm_bank_ecc;
  logic             inj_req;
  logic             inj_persist;
  logic [1:0]       inj_bank;
  logic [IW-1:0]    inj_idx;
  logic [DW+EW-1:0] inj_mask;
  logic             inj_busy;
  logic             inj_done;
  logic [CW-1:0]    inj_count;

  int numChecks = 0;
  int numPass   = 0;

  el2_dccm_sram_sink #(
    .NUM_BANKS  (NB),
    .DATA_WIDTH (DW),
    .ECC_WIDTH  (EW),
    .IDX_WIDTH  (IW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .dccm_clken        (dccm_clken),
    .dccm_wren_bank    (dccm_wren_bank),
    .dccm_addr_bank    (dccm_addr_bank),
    .dccm_wr_data_bank (dccm_wr_data_bank),
    .dccm_wr_ecc_bank  (dccm_wr_ecc_bank),
    .dccm_bank_dout    (dccm_bank_dout),
    .dccm_bank_ecc     (dccm_bank_ecc),
    .inj_req           (inj_req),
    .inj_persist       (inj_persist),
    .inj_bank          (inj_bank),
    .inj_idx           (inj_idx),
    .inj_mask          (inj_mask),
    .inj_busy          (inj_busy),
    .inj_done          (inj_done),
    .inj_count         (inj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got === exp) numPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1ns after each edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleAll();
    dccm_clken     = '0;
    dccm_wren_bank = '0;
  endtask

  task automatic setWrite(input int b, input logic [IW-1:0] idx, input logic [DW-1:0] d, input logic [EW-1:0] e);
    dccm_clken[b]                 = 1'b1;
    dccm_wren_bank[b]             = 1'b1;
    dccm_addr_bank[b*IW +: IW]    = idx;
    dccm_wr_data_bank[b*DW +: DW] = d;
    dccm_wr_ecc_bank[b*EW +: EW]  = e;
  endtask

  task automatic setRead(input int b, input logic [IW-1:0] idx);
    dccm_clken[b]              = 1'b1;
    dccm_wren_bank[b]          = 1'b0;
    dccm_addr_bank[b*IW +: IW] = idx;
  endtask

  task automatic request(input logic persist, input logic [1:0] b, input logic [IW-1:0] idx, input logic [DW+EW-1:0] m);
    inj_req     = 1'b1;
    inj_persist = persist;
    inj_bank    = b;
    inj_idx     = idx;
    inj_mask    = m;
  endtask

  function automatic logic [DW-1:0] dout(input int b);
    return dccm_bank_dout[b*DW +: DW];
  endfunction

  function automatic logic [EW-1:0] ecc(input int b);
    return dccm_bank_ecc[b*EW +: EW];
  endfunction

  initial begin
    rst_l = 1'b0;
    dccm_clken = '0; dccm_wren_bank = '0; dccm_addr_bank = '0;
    dccm_wr_data_bank = '0; dccm_wr_ecc_bank = '0;
    inj_req = 1'b0; inj_persist = 1'b0; inj_bank = '0; inj_idx = '0; inj_mask = '0;
    applyStimulus(2);
    checkOutput("rst_dout", 64'(dccm_bank_dout), 64'h0);
    checkOutput("rst_ecc", 64'(dccm_bank_ecc), 64'h0);
    checkOutput("rst_busy", 64'(inj_busy), 64'h0);
    checkOutput("rst_done", 64'(inj_done), 64'h0);
    checkOutput("rst_count", 64'(inj_count), 64'h0);
    rst_l = 1'b1;
    applyStimulus(1);

    // Write then read bank2, then hold clken low.
    setWrite(2, 12'h010, 32'hDEADBEEF, 7'h2A);
    applyStimulus(1);
    checkOutput("no_write_through", 64'(dout(2)), 64'h0);
    idleAll(); setRead(2, 12'h010);
    applyStimulus(1);
    checkOutput("b2_dout", 64'(dout(2)), 64'hDEADBEEF);
    checkOutput("b2_ecc", 64'(ecc(2)), 64'h2A);
    idleAll();
    applyStimulus(5);
    checkOutput("b2_hold", 64'(dout(2)), 64'hDEADBEEF);

    // Independent banks.
    setWrite(0, 12'h003, 32'hA5A5A5A5, 7'h3C);
    setWrite(1, 12'h005, 32'h00000001, 7'h11);
    setWrite(3, 12'h007, 32'h12345678, 7'h05);
    applyStimulus(1);
    idleAll(); setRead(0, 12'h003); setWrite(1, 12'h006, 32'h00000002, 7'h00);
    applyStimulus(1);
    checkOutput("b0_rd", 64'(dout(0)), 64'hA5A5A5A5);
    idleAll();
    setWrite(0, 12'h003, 32'h0F0F0F0F, 7'h01); setRead(1, 12'h005); setRead(3, 12'h007);
    applyStimulus(1);
    checkOutput("b0_wr_keeps_dout", 64'(dout(0)), 64'hA5A5A5A5);
    checkOutput("b1_dout", 64'(dout(1)), 64'h1);
    checkOutput("b1_ecc", 64'(ecc(1)), 64'h11);
    checkOutput("b3_dout", 64'(dout(3)), 64'h12345678);
    checkOutput("b3_ecc", 64'(ecc(3)), 64'h05);
    idleAll(); setRead(0, 12'h003);
    applyStimulus(1);
    checkOutput("b0_new", 64'(dout(0)), 64'h0F0F0F0F);

    // Transient injection on bank1 idx5, mask bit0.
    idleAll();
    request(1'b0, 2'd1, 12'h005, 39'h1);
    applyStimulus(1);
    inj_req = 1'b0;
    checkOutput("t_busy", 64'(inj_busy), 64'h1);
    setRead(1, 12'h006);
    applyStimulus(1);
    checkOutput("t_nontarget_dout", 64'(dout(1)), 64'h2);
    checkOutput("t_nontarget_done", 64'(inj_done), 64'h0);
    setWrite(1, 12'h005, 32'h00000001, 7'h22);
    applyStimulus(1);
    checkOutput("t_after_wr_busy", 64'(inj_busy), 64'h1);
    setRead(1, 12'h005);
    request(1'b1, 2'd0, 12'h003, 39'h1);
    applyStimulus(1);
    inj_req = 1'b0;
    checkOutput("t_flip_dout", 64'(dout(1)), 64'h0);
    checkOutput("t_flip_ecc", 64'(ecc(1)), 64'h22);
    checkOutput("t_done", 64'(inj_done), 64'h1);
    checkOutput("t_count", 64'(inj_count), 64'h1);
    checkOutput("t_sameedge_req_ignored", 64'(inj_busy), 64'h0);
    applyStimulus(1);
    checkOutput("t_second_dout", 64'(dout(1)), 64'h1);
    checkOutput("t_second_done", 64'(inj_done), 64'h0);

    // Persistent injection on bank3 idx7, ecc bit6, bank busy 4 cycles.
    idleAll(); setRead(3, 12'h007);
    request(1'b1, 2'd3, 12'h007, 39'h40_0000_0000);
    applyStimulus(1);
    checkOutput("p_busy", 64'(inj_busy), 64'h1);
    request(1'b0, 2'd0, 12'h003, 39'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("p_wait_ecc", 64'(ecc(3)), 64'h05);
      checkOutput("p_wait_done", 64'(inj_done), 64'h0);
      checkOutput("p_wait_busy", 64'(inj_busy), 64'h1);
    end
    inj_req = 1'b0;
    idleAll();
    applyStimulus(1);
    checkOutput("p_done", 64'(inj_done), 64'h1);
    checkOutput("p_count", 64'(inj_count), 64'h2);
    checkOutput("p_idle", 64'(inj_busy), 64'h0);
    applyStimulus(1);
    checkOutput("p_done_pulse", 64'(inj_done), 64'h0);
    checkOutput("p_count_hold", 64'(inj_count), 64'h2);
    setRead(3, 12'h007);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput("p_rd_ecc", 64'(ecc(3)), 64'h45);
      checkOutput("p_rd_dout", 64'(dout(3)), 64'h12345678);
    end

    // Reset while armed for a transient flip.
    idleAll();
    request(1'b0, 2'd1, 12'h005, 39'h1);
    applyStimulus(1);
    inj_req = 1'b0;
    checkOutput("r_armed", 64'(inj_busy), 64'h1);
    rst_l = 1'b0;
    #1;
    checkOutput("r_busy", 64'(inj_busy), 64'h0);
    checkOutput("r_count", 64'(inj_count), 64'h0);
    checkOutput("r_dout", 64'(dccm_bank_dout), 64'h0);
    #1;
    rst_l = 1'b1;
    setRead(1, 12'h005); setRead(3, 12'h007);
    applyStimulus(1);
    checkOutput("r_uncorrupted", 64'(dout(1)), 64'h1);
    checkOutput("r_done", 64'(inj_done), 64'h0);
    checkOutput("r_array_kept", 64'(ecc(3)), 64'h45);

    // Zero-mask persistent injections until the counter saturates.
    idleAll();
    for (int k = 1; k <= 9; k++) begin
      request(1'b1, 2'd0, 12'h003, 39'h0);
      applyStimulus(1);
      inj_req = 1'b0;
      applyStimulus(1);
      checkOutput("s_done", 64'(inj_done), 64'h1);
      checkOutput("s_count", 64'(inj_count), 64'((k > 7) ? 7 : k));
      applyStimulus(1);
    end
    setRead(0, 12'h003);
    applyStimulus(1);
    checkOutput("s_zero_mask_data", 64'(dout(0)), 64'h0F0F0F0F);
    checkOutput("s_zero_mask_ecc", 64'(ecc(0)), 64'h01);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule

// File: doc/el2_dccm_sram_sink.md
Name: el2_dccm_sram_sink

Overview:
- Memory-side responder for the DCCM half of the core-to-SRAM memory interface. It owns the banked data and ECC storage that the core's DCCM controller drives.
- Each bank takes clock-enable, write-enable, address, write data and write ECC, and returns registered read data and ECC with 1-cycle latency.
- Includes an error-injection engine so benches can exercise the core's DCCM ECC correction and detection paths without a separate memory model.

Parameters:
- NUM_BANKS, 4, number of DCCM banks.
- DATA_WIDTH, 32, data bits per bank word.
- ECC_WIDTH, 7, ECC bits per bank word.
- IDX_WIDTH, 12, bank row-index width; depth per bank = 2**IDX_WIDTH.
- CNT_WIDTH, 16, width of the injection event counter.

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- dccm_clken  in  NUM_BANKS  per-bank access enable
- dccm_wren_bank  in  NUM_BANKS  per-bank write enable (qualified by clken)
- dccm_addr_bank  in  NUM_BANKS*IDX_WIDTH  per-bank row index
- dccm_wr_data_bank  in  NUM_BANKS*DATA_WIDTH  write data
- dccm_wr_ecc_bank  in  NUM_BANKS*ECC_WIDTH  write ECC
- dccm_bank_dout  out  NUM_BANKS*DATA_WIDTH  registered read data
- dccm_bank_ecc  out  NUM_BANKS*ECC_WIDTH  registered read ECC
- inj_req  in  1  injection request pulse
- inj_persist  in  1  0 = transient (flip output once), 1 = persistent (flip stored word)
- inj_bank  in  $clog2(NUM_BANKS)  target bank
- inj_idx  in  IDX_WIDTH  target row
- inj_mask  in  DATA_WIDTH+ECC_WIDTH  XOR mask, {ecc,data}
- inj_busy  out  1  engine armed
- inj_done  out  1  1-cycle pulse when the injection takes effect
- inj_count  out  CNT_WIDTH  saturating count of completed injections

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_l).
- Reset values:
  - dout/ecc = 0, inj_busy = 0, inj_done = 0, inj_count = 0, FSM = IDLE.
  - Array contents are not reset (X in simulation).
- Bank access:
  - clken & wren: write {ecc,data} to array[idx] at the clock edge. dout/ecc are unchanged that cycle; there is no write-through.
  - clken & !wren: dout/ecc <= array[idx] at the edge, so data is visible the cycle after the request (latency 1).
  - !clken: dout/ecc hold their last value indefinitely.
  - Banks are fully independent; any mix of simultaneous bank accesses is legal.
- Injection FSM states: IDLE, ARM_T, ARM_P.
  - IDLE:
    - inj_req & !inj_persist -> ARM_T.
    - inj_req & inj_persist -> ARM_P.
    - The request fields are latched on the accepting edge.
  - ARM_T: on a read of the target bank at the target idx, that read's output is loaded as array[idx] XOR mask. The stored word is untouched. -> IDLE, and inj_done pulses in the cycle the corrupted dout is visible.
  - ARM_P:
    - In the first cycle with target-bank clken = 0: array[idx] <= array[idx] XOR mask. -> IDLE, and inj_done pulses the following cycle.
    - While the bank is busy, the engine waits indefinitely; it never collides with core traffic.
  - inj_busy = (state != IDLE).
  - inj_req while busy is ignored. No queueing, no count change.
- inj_count increments on each inj_done and saturates at all-ones.
- Boundary rules:
  - A core write to the target idx while in ARM_T: the new data is what gets flipped on the next matching read.
  - A read to a non-target idx in the target bank does not fire the injection.
  - A zero mask still completes and counts.
  - inj_req arriving in the same cycle the FSM returns to IDLE is ignored; acceptance is based on the registered state.
  - rst_l asserted mid-arm: the FSM returns to IDLE and the armed request is discarded. Any array write from a prior completed persistent flip remains.

Decomposition:
- Shared package el2_dccm_sink_pkg:
  - inj_state_e enum (IDLE/ARM_T/ARM_P).
  - Typedef for the {ecc,data} word.
- One natural sub-module, el2_dccm_sink_bank: single-bank array plus output register, with a one-word XOR overlay input and a read-modify-write strobe.
- The top instantiates NUM_BANKS of these plus the injection FSM and counter.

Test Plan:
- Write bank2 idx 0x010 data 0xDEADBEEF ecc 0x2A; read it next cycle -> dout[2] = 0xDEADBEEF, ecc[2] = 0x2A one cycle after the read. Hold clken low 5 cycles -> dout unchanged.
- Simultaneous write on bank0 and reads on banks 1/3 -> each bank behaves independently; a write cycle does not alter dout[0].
- Transient injection on bank1 idx 5, mask bit0, over word 0x00000001:
  - First read -> 0x00000000, with inj_done pulse and count = 1.
  - Second read -> 0x00000001.
- Persistent injection on bank3 idx 7, mask {ecc bit6}, with bank3 kept busy 4 cycles:
  - No flip while busy.
  - Flip lands in the first idle cycle; done pulses the next cycle.
  - Every later read returns ecc XOR 0x40.
- inj_req while busy -> ignored, count unchanged. Assert rst_l low while in ARM_T -> busy = 0, count = 0, the next matching read is uncorrupted.
- Force count to all-ones minus 1, run 2 injections -> count saturates at all-ones.
